// File: rtl/mem_write_checker_pkg.sv
// memchk_pkg: shared state encoding and failure codes for the memory write checker
package memchk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} memchk_state_t;
    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ADDR    = 3'd1;
    localparam logic [2:0] FC_DATA    = 3'd2;
    localparam logic [2:0] FC_TIMEOUT = 3'd3;
    localparam logic [2:0] FC_CFG     = 3'd4;
endpackage

// File: rtl/mem_write_checker_if.sv
// mem_write_checker_if: config, monitored write bus and status of the write checker
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LEN_W = $clog2(DEPTH + 1);
    logic              start;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [LEN_W-1:0]  cfg_len;
    logic [ADDR_W-1:0] ign_lo;
    logic [ADDR_W-1:0] ign_hi;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [2:0]        fail_code;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic [LEN_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  cycles;
    modport master (
        output start, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_len, ign_lo, ign_hi,
        output memwrite, dataadr, writedata,
        input  busy, done, pass, fail_code, fail_addr, fail_data, match_cnt, cycles
    );
    modport slave (
        input  start, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_len, ign_lo, ign_hi,
        input  memwrite, dataadr, writedata,
        output busy, done, pass, fail_code, fail_addr, fail_data, match_cnt, cycles
    );
endinterface

// File: rtl/mem_write_checker_table.sv
// memchk_table: expected (address, data) register file, sync write, async read
module memchk_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (we && int'(widx) < DEPTH) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    assign raddr = addr_mem[ridx];
    assign rdata = data_mem[ridx];
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares non-ignored memory writes in order against a programmed table
module mem_write_checker
    import memchk_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 32
) (
    input logic clk,
    input logic rst,
    mem_write_checker_if.slave bus
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    memchk_state_t     state, nxt;
    logic [LEN_W-1:0]  match_cnt, len_q, cnt_inc;
    logic [CNT_W-1:0]  cycles;
    logic [2:0]        fail_code, code_n;
    logic [ADDR_W-1:0] fail_addr, lo_q, hi_q, t_addr;
    logic [DATA_W-1:0] fail_data, t_data;
    logic              hit, wr, inc, cap, arm, tmo;

    memchk_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.cfg_we && state != RUN),
        .widx  (bus.cfg_idx),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .ridx  (match_cnt[IDX_W-1:0]),
        .raddr (t_addr),
        .rdata (t_data)
    );

    // A matched write that does not finish the sequence still lets the timeout fire
    always_comb begin
        hit     = bus.dataadr >= lo_q && bus.dataadr <= hi_q;
        wr      = state == RUN && bus.memwrite && !hit;
        cnt_inc = match_cnt + 1'b1;
        tmo     = TIMEOUT != 0 && cycles == TMO_M1;
        inc     = wr && bus.dataadr == t_addr && bus.writedata == t_data;
        cap     = wr && !inc;
        arm     = 1'b0;
        nxt     = state;
        code_n  = fail_code;
        if (state == RUN) begin
            if (cap) begin
                nxt    = FAIL;
                code_n = bus.dataadr != t_addr ? FC_ADDR : FC_DATA;
            end else if (inc && cnt_inc == len_q) begin
                nxt = PASS;
            end else if (tmo) begin
                nxt    = FAIL;
                code_n = FC_TIMEOUT;
            end
        end else if (bus.start) begin
            arm    = bus.cfg_len != '0 && bus.cfg_len <= MAX_LEN;
            nxt    = arm ? RUN : FAIL;
            code_n = arm ? FC_NONE : FC_CFG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            match_cnt <= '0;
            cycles    <= '0;
            fail_code <= FC_NONE;
            fail_addr <= '0;
            fail_data <= '0;
            len_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            state     <= nxt;
            fail_code <= code_n;
            if (arm) begin
                match_cnt <= '0;
                cycles    <= '0;
                fail_addr <= '0;
                fail_data <= '0;
                len_q     <= bus.cfg_len;
                lo_q      <= bus.ign_lo;
                hi_q      <= bus.ign_hi;
            end
            if (state == RUN && cycles != '1) cycles <= cycles + 1'b1;
            if (inc) match_cnt <= cnt_inc;
            if (cap) begin
                fail_addr <= bus.dataadr;
                fail_data <= bus.writedata;
            end
        end
    end

    assign bus.busy      = state == RUN;
    assign bus.done      = state == PASS || state == FAIL;
    assign bus.pass      = state == PASS;
    assign bus.fail_code = fail_code;
    assign bus.fail_addr = fail_addr;
    assign bus.fail_data = fail_data;
    assign bus.match_cnt = match_cnt;
    assign bus.cycles    = cycles;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed and randomized checks against a run-level reference model
module tb_mem_write_checker;
    localparam int TMO = 50;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .CNT_W(32)) bus ();
    mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    bit m_run, m_pass, m_fail;
    int m_code, m_cnt, m_len;
    logic [31:0] m_fa, m_fd, m_cyc, m_lo, m_hi;
    logic [31:0] ta [4];
    logic [31:0] td [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a run walks the expected list; any other non-ignored write ends it
    task automatic model_step();
        if (!rst) begin
            {m_run, m_pass, m_fail} = 3'b000;
            m_code = 0; m_cnt = 0; m_len = 0;
            m_fa = 0; m_fd = 0; m_cyc = 0;
            for (int i = 0; i < 4; i++) begin ta[i] = 0; td[i] = 0; end
        end else if (m_run) begin
            if (m_cyc != 32'hffff_ffff) m_cyc++;
            if (bus.memwrite && !(bus.dataadr >= m_lo && bus.dataadr <= m_hi)) begin
                if (bus.dataadr != ta[m_cnt] || bus.writedata != td[m_cnt]) begin
                    m_run = 0; m_fail = 1;
                    m_code = bus.dataadr != ta[m_cnt] ? 1 : 2;
                    m_fa = bus.dataadr; m_fd = bus.writedata;
                end else begin
                    m_cnt++;
                    if (m_cnt == m_len) begin m_run = 0; m_pass = 1; end
                end
            end
            if (m_run && m_cyc == TMO) begin m_run = 0; m_fail = 1; m_code = 3; end
        end else begin
            if (bus.cfg_we) begin ta[bus.cfg_idx] = bus.cfg_addr; td[bus.cfg_idx] = bus.cfg_data; end
            if (bus.start) begin
                m_pass = 0;
                if (bus.cfg_len == 0 || bus.cfg_len > 4) begin
                    m_fail = 1; m_code = 4;
                end else begin
                    m_run = 1; m_fail = 0; m_code = 0; m_fa = 0; m_fd = 0; m_cnt = 0; m_cyc = 0;
                    m_len = int'(bus.cfg_len); m_lo = bus.ign_lo; m_hi = bus.ign_hi;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("busy", 64'(bus.busy), 64'(m_run));
        chk("done", 64'(bus.done), 64'(m_pass | m_fail));
        chk("pass", 64'(bus.pass), 64'(m_pass));
        chk("fail_code", 64'(bus.fail_code), 64'(m_code));
        chk("fail_addr", 64'(bus.fail_addr), 64'(m_fa));
        chk("fail_data", 64'(bus.fail_data), 64'(m_fd));
        chk("match_cnt", 64'(bus.match_cnt), 64'(m_cnt));
        chk("cycles", 64'(bus.cycles), 64'(m_cyc));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        bus.cfg_we = 1; bus.cfg_idx = 2'(idx); bus.cfg_addr = a; bus.cfg_data = d;
        cycle();
        bus.cfg_we = 0;
    endtask

    task automatic arm(input int len, input logic [31:0] lo, input logic [31:0] hi);
        bus.cfg_len = 3'(len); bus.ign_lo = lo; bus.ign_hi = hi; bus.start = 1;
        cycle();
        bus.start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite = 1; bus.dataadr = a; bus.writedata = d;
        cycle();
        bus.memwrite = 0;
    endtask

    initial begin
        {bus.start, bus.cfg_we, bus.memwrite} = 3'b000;
        bus.cfg_idx = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.cfg_len = 0;
        bus.ign_lo = 0; bus.ign_hi = 0; bus.dataadr = 0; bus.writedata = 0;
        repeat (2) cycle();
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_code", 64'(bus.fail_code), 0);
        rst = 1;

        load(0, 84, 7);
        arm(1, 80, 80);
        wr(80, 5); wr(80, 9); wr(84, 7);
        chk("legacy_pass", 64'(bus.pass), 1);
        chk("legacy_cnt", 64'(bus.match_cnt), 1);
        chk("legacy_code", 64'(bus.fail_code), 0);

        load(0, 32'h10, 1); load(1, 32'h14, 2); load(2, 32'h18, 3);
        arm(3, 32'h100, 32'h1ff);
        wr(32'h10, 1); wr(32'h150, 0); wr(32'h14, 2); cycle(); wr(32'h1ff, 5);
        chk("seq_busy", 64'(bus.busy), 1);
        wr(32'h18, 3);
        chk("seq_pass", 64'(bus.pass), 1);
        arm(3, 32'h100, 32'h1ff);
        wr(32'h14, 2);
        chk("swap_code", 64'(bus.fail_code), 1);
        chk("swap_addr", 64'(bus.fail_addr), 32'h14);

        load(0, 84, 7);
        arm(1, 1, 0);
        wr(84, 6);
        chk("data_code", 64'(bus.fail_code), 2);
        chk("data_addr", 64'(bus.fail_addr), 84);
        chk("data_data", 64'(bus.fail_data), 6);

        arm(1, 1, 0);
        chk("tmo_cyc0", 64'(bus.cycles), 0);
        repeat (49) cycle();
        chk("tmo_pre_busy", 64'(bus.busy), 1);
        cycle();
        chk("tmo_code", 64'(bus.fail_code), 3);
        chk("tmo_cycles", 64'(bus.cycles), 50);
        arm(1, 1, 0);
        repeat (49) cycle();
        wr(84, 7);
        chk("tmo_last_pass", 64'(bus.pass), 1);
        chk("tmo_last_cyc", 64'(bus.cycles), 50);

        arm(0, 0, 0);
        chk("cfg0_code", 64'(bus.fail_code), 4);
        arm(5, 0, 0);
        chk("cfg5_code", 64'(bus.fail_code), 4);
        load(0, 32'h20, 32'ha); load(1, 32'h24, 32'hb);
        arm(2, 1, 0);
        chk("rearm_cnt", 64'(bus.match_cnt), 0);
        chk("rearm_code", 64'(bus.fail_code), 0);
        load(0, 32'h99, 32'h99);
        wr(32'h20, 32'ha); wr(32'h24, 32'hb);
        chk("rearm_pass", 64'(bus.pass), 1);

        load(0, 32'h30, 1); load(1, 32'h34, 2); load(2, 32'h38, 3);
        arm(3, 1, 0);
        wr(32'h30, 1); wr(32'h34, 2);
        chk("mid_cnt", 64'(bus.match_cnt), 2);
        rst = 0;
        cycle();
        chk("mid_busy", 64'(bus.busy), 0);
        chk("mid_cnt0", 64'(bus.match_cnt), 0);
        rst = 1;
        arm(3, 1, 0);
        wr(32'h30, 1);
        chk("mid_code", 64'(bus.fail_code), 1);
        chk("mid_addr", 64'(bus.fail_addr), 32'h30);

        for (int r = 0; r < 30; r++) begin
            int len;
            logic [31:0] lo, hi;
            for (int i = 0; i < 4; i++) load(i, 32'h10 + 4 * $urandom_range(0, 7), 32'($urandom_range(0, 3)));
            len = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
            lo = 32'h10 + 4 * $urandom_range(0, 8);
            hi = 32'h10 + 4 * $urandom_range(0, 8);
            arm(len, lo, hi);
            for (int c = 0; c < 40 && m_run; c++) begin
                int p;
                p = int'($urandom_range(0, 9));
                bus.cfg_we = p == 9; bus.start = p == 8;
                bus.cfg_idx = 2'($urandom_range(0, 3)); bus.cfg_addr = $urandom; bus.cfg_data = $urandom;
                if (p < 5) wr(ta[m_cnt], td[m_cnt]);
                else if (p < 7) wr(32'h10 + 4 * $urandom_range(0, 8), 32'($urandom_range(0, 3)));
                else cycle();
                bus.cfg_we = 0; bus.start = 0;
            end
            while (m_run) cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
